// File: rtl/rpn_pkg.sv
// rpn_pkg: shared types and constants for the RPN program sequencer.
//   kind_t  - instruction kind field [17:16]
//   state_t - sequencer FSM states
//   err_t   - error codes reported on err_code
//   OP_*    - calculator op encodings
//   op_need - number of stack operands an op consumes
package rpn_pkg;

   localparam int KIND_W  = 2;
   localparam int IMM_W   = 16;
   localparam int OP_W    = 2;
   localparam int INSTR_W = KIND_W + IMM_W;
   localparam int DATA_W  = 16;
   localparam int CNT_W   = 10;

   typedef enum logic [KIND_W-1:0] {
      K_PUSH = 2'b00,
      K_OP   = 2'b01,
      K_HALT = 2'b10,
      K_NOP  = 2'b11
   } kind_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLR,
      S_RUN,
      S_DONE,
      S_ERR
   } state_t;

   typedef enum logic [1:0] {
      E_NONE  = 2'b00,
      E_UNDER = 2'b01,
      E_OVER  = 2'b10,
      E_UNBAL = 2'b11
   } err_t;

   localparam logic [OP_W-1:0] OP_NONE = 2'b00;
   localparam logic [OP_W-1:0] OP_NEG  = 2'b01;
   localparam logic [OP_W-1:0] OP_ADD  = 2'b10;
   localparam logic [OP_W-1:0] OP_MUL  = 2'b11;

   // Operands that must already be on the stack for an op to be legal.
   // OP_NONE behaves as a NOP and needs nothing.
   function automatic logic [1:0] op_need(input logic [OP_W-1:0] o);
      case (o)
         OP_NEG:         op_need = 2'd1;
         OP_ADD, OP_MUL: op_need = 2'd2;
         default:        op_need = 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/rpn_sequencer_prog_mem.sv
// prog_mem: 2^AW x INSTR_W instruction RAM.
//   step  - clock
//   we    - write enable (gated by the sequencer when busy)
//   waddr - write address, wdata - write word (lands on the step edge)
//   raddr - read address, rdata - asynchronous read data
module prog_mem
   import rpn_pkg::*;
#(
   parameter int AW = 6
) (
   input  logic               step,
   input  logic               we,
   input  logic [AW-1:0]      waddr,
   input  logic [INSTR_W-1:0] wdata,
   input  logic [AW-1:0]      raddr,
   output logic [INSTR_W-1:0] rdata
);

   logic [INSTR_W-1:0] mem [0:(1<<AW)-1];

   always_ff @(posedge step) begin
      if (we)
         mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/rpn_sequencer.sv
// rpn_sequencer: program sequencer for the 16-bit RPN stack calculator.
// Holds a host-loaded program, clears the calculator on start and issues one
// instruction per step, refusing any instruction that would underflow or
// overflow the calculator stack, and checking the stack is balanced at HALT.
//   step, nrst           - clock, asynchronous active-low reset
//   load_we/addr/data    - program write port (idle/done/err only)
//   start                - begin a run (idle/done/err only)
//   cnt, top             - calculator depth and top-of-stack
//   push, op, d          - calculator command outputs (combinational)
//   stk_nrst             - registered calculator clear, low for the CLR cycle
//   busy, done, err      - status decoded from state
//   err_code, pc, result - error code, current address, value at HALT
module rpn_sequencer
   import rpn_pkg::*;
#(
   parameter int AW   = 6,
   parameter int SMAX = 1023
) (
   input  logic               step,
   input  logic               nrst,
   input  logic               load_we,
   input  logic [AW-1:0]      load_addr,
   input  logic [INSTR_W-1:0] load_data,
   input  logic               start,
   input  logic [CNT_W-1:0]   cnt,
   input  logic [DATA_W-1:0]  top,
   output logic               push,
   output logic [OP_W-1:0]    op,
   output logic [DATA_W-1:0]  d,
   output logic               stk_nrst,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [1:0]         err_code,
   output logic [AW-1:0]      pc,
   output logic [DATA_W-1:0]  result
);

   localparam logic [CNT_W-1:0] SMAX_C  = CNT_W'(SMAX);
   localparam logic [AW-1:0]    PC_LAST = {AW{1'b1}};

   state_t              state, state_nx;
   err_t                ec, ec_nx;
   logic [AW-1:0]       pc_nx;
   logic [DATA_W-1:0]   result_nx;
   logic [INSTR_W-1:0]  instr;
   kind_t               kind;
   logic [IMM_W-1:0]    imm;
   logic [OP_W-1:0]     opf;
   logic                idle_like;
   logic                adv;

   assign idle_like = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);

   prog_mem #(.AW(AW)) u_mem (
      .step  (step),
      .we    (load_we && idle_like),
      .waddr (load_addr),
      .wdata (load_data),
      .raddr (pc),
      .rdata (instr)
   );

   assign kind = kind_t'(instr[INSTR_W-1:IMM_W]);
   assign imm  = instr[IMM_W-1:0];
   assign opf  = instr[OP_W-1:0];

   // Next state, legality check and command decode. Illegal instructions
   // are never issued and leave pc on the faulting address.
   always_comb begin
      state_nx  = state;
      pc_nx     = pc;
      ec_nx     = ec;
      result_nx = result;
      push      = 1'b0;
      op        = OP_NONE;
      d         = '0;
      adv       = 1'b0;
      case (state)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_nx = S_CLR;
               pc_nx    = '0;
               ec_nx    = E_NONE;
            end
         end
         S_CLR: state_nx = S_RUN;
         S_RUN: begin
            case (kind)
               K_PUSH: begin
                  if (cnt == SMAX_C) begin
                     state_nx = S_ERR;
                     ec_nx    = E_OVER;
                  end else begin
                     push = 1'b1;
                     d    = imm;
                     adv  = 1'b1;
                  end
               end
               K_OP: begin
                  if (cnt < CNT_W'(op_need(opf))) begin
                     state_nx = S_ERR;
                     ec_nx    = E_UNDER;
                  end else begin
                     op  = opf;
                     adv = 1'b1;
                  end
               end
               K_HALT: begin
                  if (cnt == CNT_W'(1)) begin
                     state_nx  = S_DONE;
                     result_nx = top;
                  end else begin
                     state_nx = S_ERR;
                     ec_nx    = E_UNBAL;
                  end
               end
               default: adv = 1'b1;
            endcase
            // Running off the end of memory counts as a missing HALT; pc
            // stays on the last address rather than wrapping.
            if (adv) begin
               if (pc == PC_LAST) begin
                  state_nx = S_ERR;
                  ec_nx    = E_UNBAL;
               end else begin
                  pc_nx = pc + 1'b1;
               end
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge step or negedge nrst) begin
      if (!nrst) begin
         state    <= S_IDLE;
         pc       <= '0;
         ec       <= E_NONE;
         result   <= '0;
         stk_nrst <= 1'b1;
      end else begin
         state    <= state_nx;
         pc       <= pc_nx;
         ec       <= ec_nx;
         result   <= result_nx;
         // Registered so the calculator clear is glitch-free and covers
         // exactly the CLR cycle.
         stk_nrst <= (state_nx != S_CLR);
      end
   end

   assign busy     = (state == S_CLR) || (state == S_RUN);
   assign done     = (state == S_DONE);
   assign err      = (state == S_ERR);
   assign err_code = ec;

endmodule

// File: tb/tb_rpn_sequencer.sv
module tb_rpn_sequencer;

   localparam int AW = 6;
   localparam logic [17:0] HALT_W = 18'h20000;
   localparam logic [17:0] NOP_W  = 18'h30000;

   logic        step = 1'b0;
   logic        nrst = 1'b0;
   logic        load_we = 1'b0;
   logic [AW-1:0] load_addr = '0;
   logic [17:0] load_data = '0;
   logic        start = 1'b0;
   logic [9:0]  cnt;
   logic [15:0] top;
   logic        push;
   logic [1:0]  op;
   logic [15:0] d;
   logic        stk_nrst, busy, done, err;
   logic [1:0]  err_code;
   logic [AW-1:0] pc;
   logic [15:0] result;

   int checks = 0;
   int errors = 0;

   always #5 step = ~step;

   rpn_sequencer #(.AW(AW), .SMAX(1023)) dut (
      .step(step), .nrst(nrst), .load_we(load_we), .load_addr(load_addr),
      .load_data(load_data), .start(start), .cnt(cnt), .top(top),
      .push(push), .op(op), .d(d), .stk_nrst(stk_nrst), .busy(busy),
      .done(done), .err(err), .err_code(err_code), .pc(pc), .result(result)
   );

   // Calculator stand-in: a value stack driven by the DUT's commands.
   // "stub" forces the reported depth to full.
   logic [15:0] cq[$];
   logic [9:0]  calc_cnt = '0;
   logic [15:0] calc_top = '0;
   logic [15:0] ca, cb;
   bit          stub = 1'b0;

   always @(posedge step or negedge nrst or negedge stk_nrst) begin
      if (!nrst || !stk_nrst) begin
         cq.delete();
      end else if (push) begin
         cq.push_back(d);
      end else if (op == 2'b01 && cq.size() >= 1) begin
         cq[cq.size()-1] = -cq[cq.size()-1];
      end else if (op[1] && cq.size() >= 2) begin
         ca = cq.pop_back();
         cb = cq.pop_back();
         cq.push_back(op[0] ? 16'(ca * cb) : 16'(ca + cb));
      end
      calc_cnt <= 10'(cq.size());
      calc_top <= (cq.size() > 0) ? cq[cq.size()-1] : 16'h0;
   end

   assign cnt = stub ? 10'd1023 : calc_cnt;
   assign top = calc_top;

   // Reference: the run is executed symbolically from the program rules into
   // a list of expected per-cycle outputs.
   typedef struct {
      logic        busy, done, err, stkn, push;
      logic [1:0]  op;
      logic [15:0] d;
      logic [5:0]  pc;
      logic [1:0]  ec;
      logic [15:0] res;
      logic [9:0]  cnt;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        ce;
   logic [17:0] mem_m [0:63];
   logic [15:0] last_res = '0;
   int          fin_edges;
   bit          fin_done;
   logic [1:0]  fin_ec;
   logic [5:0]  fin_pc;
   logic [15:0] fin_res;

   function automatic exp_t mk(logic b, logic dn, logic er, logic sk, logic p,
                               logic [1:0] o, logic [15:0] dd, logic [5:0] a,
                               logic [1:0] ec, logic [15:0] r, logic [9:0] c);
      exp_t e;
      e.busy = b; e.done = dn; e.err = er; e.stkn = sk; e.push = p;
      e.op = o; e.d = dd; e.pc = a; e.ec = ec; e.res = r; e.cnt = c;
      return e;
   endfunction

   task automatic build_trace(input bit stb);
      exp_t        e;
      int          depth, i, n, need;
      logic [15:0] vals[$];
      logic [15:0] a, b;
      logic [17:0] w;
      bit          ended;
      depth = stb ? 1023 : 0;
      exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, last_res, depth[9:0]));
      n = 1; i = 0; ended = 0;
      fin_done = 0; fin_ec = 0; fin_pc = 0; fin_res = last_res;
      while (!ended) begin
         w = mem_m[i];
         e = mk(1, 0, 0, 1, 0, 0, 0, i[5:0], 0, last_res, depth[9:0]);
         case (w[17:16])
            2'b00: begin
               if (depth == 1023) begin
                  fin_ec = 2'b10; ended = 1;
               end else begin
                  e.push = 1; e.d = w[15:0];
                  vals.push_back(w[15:0]); depth++;
               end
            end
            2'b01: begin
               need = (w[1:0] == 2'b00) ? 0 : (w[1:0] == 2'b01) ? 1 : 2;
               if (depth < need) begin
                  fin_ec = 2'b01; ended = 1;
               end else begin
                  e.op = w[1:0];
                  if (w[1:0] == 2'b01 && vals.size() > 0) begin
                     vals[vals.size()-1] = 16'(0 - vals[vals.size()-1]);
                  end else if (w[1] && vals.size() > 1) begin
                     a = vals.pop_back(); b = vals.pop_back();
                     vals.push_back(w[0] ? 16'(a * b) : 16'(a + b));
                  end
                  depth = depth - ((need > 1) ? 1 : 0);
               end
            end
            2'b10: begin
               ended = 1;
               if (depth == 1) begin
                  fin_done = 1; fin_res = vals[0];
               end else begin
                  fin_ec = 2'b11;
               end
            end
            default: ;
         endcase
         exp_q.push_back(e);
         n++;
         if (!ended && i == 63) begin
            fin_ec = 2'b11; ended = 1;
         end
         if (ended) fin_pc = i[5:0];
         else i++;
      end
      fin_edges = n;
      for (int k = 0; k < 3; k++)
         exp_q.push_back(mk(0, fin_done, !fin_done, 1, 0, 0, 0, fin_pc, fin_ec,
                            fin_res, depth[9:0]));
      last_res = fin_res;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
      end
   endtask

   // Per-cycle compare against the reference trace.
   always @(posedge step) begin
      #1;
      if (nrst && exp_q.size() > 0) begin
         ce = exp_q.pop_front();
         chk("cyc_busy", 32'(busy), 32'(ce.busy));
         chk("cyc_done", 32'(done), 32'(ce.done));
         chk("cyc_err", 32'(err), 32'(ce.err));
         chk("cyc_stk_nrst", 32'(stk_nrst), 32'(ce.stkn));
         chk("cyc_push", 32'(push), 32'(ce.push));
         chk("cyc_op", 32'(op), 32'(ce.op));
         chk("cyc_d", 32'(d), 32'(ce.d));
         chk("cyc_pc", 32'(pc), 32'(ce.pc));
         chk("cyc_err_code", 32'(err_code), 32'(ce.ec));
         chk("cyc_result", 32'(result), 32'(ce.res));
         chk("cyc_cnt", 32'(cnt), 32'(ce.cnt));
      end
   end

   task automatic check_reset(input string tag);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_done"}, 32'(done), 0);
      chk({tag, "_err"}, 32'(err), 0);
      chk({tag, "_stk_nrst"}, 32'(stk_nrst), 1);
      chk({tag, "_push"}, 32'(push), 0);
      chk({tag, "_op"}, 32'(op), 0);
      chk({tag, "_d"}, 32'(d), 0);
      chk({tag, "_pc"}, 32'(pc), 0);
      chk({tag, "_err_code"}, 32'(err_code), 0);
      chk({tag, "_result"}, 32'(result), 0);
   endtask

   task automatic load(input logic [5:0] a, input logic [17:0] w);
      @(negedge step);
      load_we = 1'b1; load_addr = a; load_data = w;
      mem_m[a] = w;
      @(negedge step);
      load_we = 1'b0;
   endtask

   task automatic wait_drain(input string nm);
      int t = 0;
      while (exp_q.size() != 0 && t < 300) begin
         @(negedge step);
         t++;
      end
      if (exp_q.size() != 0) begin
         chk(nm, 32'(exp_q.size()), 0);
         exp_q.delete();
      end
   endtask

   // ld_start: write (la, lw) on the start edge; ld_busy: attempt a write
   // to address 0 while the run is busy; abort: pull nrst after that many cycles.
   task automatic run(input bit stb, input bit ld_start, input logic [5:0] la,
                      input logic [17:0] lw, input bit ld_busy, input int abort);
      wait_drain("pre_run_timeout");
      @(negedge step);
      stub = stb;
      start = 1'b1;
      if (ld_start) begin
         load_we = 1'b1; load_addr = la; load_data = lw; mem_m[la] = lw;
      end
      build_trace(stb);
      @(negedge step);
      start = 1'b0;
      load_we = 1'b0;
      if (ld_busy) begin
         load_we = 1'b1; load_addr = 6'd0; load_data = 18'h01234;
         @(negedge step);
         load_we = 1'b0;
      end
      if (abort > 0) begin
         repeat (abort) @(negedge step);
         nrst = 1'b0;
         exp_q.delete();
         last_res = '0;
         #1;
         check_reset("abort");
         @(negedge step);
         nrst = 1'b1;
      end else begin
         wait_drain("run_timeout");
      end
   endtask

   task automatic rand_prog();
      int len, r;
      logic [17:0] w;
      len = $urandom_range(1, 10);
      for (int j = 0; j < len; j++) begin
         r = $urandom_range(0, 9);
         if (r < 4)      w = {2'b00, 16'($urandom_range(0, 65535))};
         else if (r < 8) w = {2'b01, 14'h0, 2'($urandom_range(0, 3))};
         else            w = NOP_W;
         load(6'(j), w);
      end
      if ($urandom_range(0, 4) != 0) load(6'(len), HALT_W);
   endtask

   initial begin
      repeat (2) @(negedge step);
      check_reset("reset");
      nrst = 1'b1;
      for (int a = 0; a < 64; a++) load(6'(a), HALT_W);

      load(0, 18'h00003); load(1, 18'h00004); load(2, 18'h10002); load(3, HALT_W);
      run(0, 0, 0, 0, 0, 0);
      chk("add_result", 32'(result), 7);
      chk("add_done", 32'(done), 1);
      chk("add_model", 32'(fin_res), 7);
      chk("add_latency", 32'(fin_edges), 5);
      // Rerun after DONE: the trace expects cnt=0 on the first RUN cycle.
      run(0, 0, 0, 0, 0, 0);
      chk("rerun_result", 32'(result), 7);

      load(0, 18'h00005); load(1, 18'h10001); load(2, HALT_W);
      run(0, 0, 0, 0, 0, 0);
      chk("neg_result", 32'(result), 32'hFFFB);

      load(0, 18'd300); load(1, 18'd300); load(2, 18'h10003); load(3, HALT_W);
      run(0, 0, 0, 0, 0, 0);
      chk("mul_result", 32'(result), 32'h5F90);

      load(0, 18'h00005); load(1, 18'h10002);
      run(0, 0, 0, 0, 0, 0);
      chk("under_code", 32'(err_code), 1);
      chk("under_pc", 32'(pc), 1);
      chk("under_cnt", 32'(cnt), 1);
      chk("under_result_held", 32'(result), 32'h5F90);

      load(0, 18'h00001); load(1, 18'h00002); load(2, HALT_W);
      run(0, 0, 0, 0, 0, 0);
      chk("unbal_code", 32'(err_code), 3);

      load(0, 18'h00009); load(1, HALT_W);
      run(1, 0, 0, 0, 0, 0);
      chk("over_code", 32'(err_code), 2);
      chk("over_pc", 32'(pc), 0);

      load(0, 18'h00001); load(1, HALT_W);
      run(0, 1, 6'd0, 18'h00008, 0, 0);
      chk("ldstart_result", 32'(result), 8);
      run(0, 0, 0, 0, 1, 0);
      chk("ldbusy_result", 32'(result), 8);

      load(0, 18'h00003); load(1, 18'h00004); load(2, 18'h10002); load(3, HALT_W);
      run(0, 0, 0, 0, 0, 2);
      run(0, 0, 0, 0, 0, 0);
      chk("post_abort_result", 32'(result), 7);

      for (int a = 0; a < 64; a++) load(6'(a), NOP_W);
      run(0, 0, 0, 0, 0, 0);
      chk("nop_end_code", 32'(err_code), 3);
      chk("nop_end_pc", 32'(pc), 63);
      for (int a = 0; a < 64; a++) load(6'(a), HALT_W);

      for (int t = 0; t < 30; t++) begin
         rand_prog();
         run(0, 0, 0, 0, 0, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
